// File: rtl/run_stepper_if.sv
// ----------------------------------------------------------------------------
// run_stepper_if
//   Groups the control, processor-handshake and trace-read signals of
//   run_stepper. Clock and Reset stay as plain ports on the design.
//
//   Signals (direction as seen by the stepper, modport slave):
//     Start       in   one-cycle request to begin stepping
//     Stop        in   one-cycle request to end stepping
//     Step_N      in   instruction budget, latched at Start; 0 = until Stop
//     Done        in   processor instruction-complete strobe
//     pc          in   processor pc, sampled in the Done cycle
//     Trace_rd    in   pop the trace FIFO head
//     Run         out  processor run enable
//     Busy        out  high while stepping
//     Err         out  per-instruction timeout flag
//     Overflow    out  sticky trace-drop flag
//     Retired     out  instructions retired since last Start
//     Trace_valid out  trace FIFO non-empty
//     Trace_pc    out  FIFO head pc (first-word fall-through)
//     Trace_cyc   out  FIFO head cycle count (first-word fall-through)
// ----------------------------------------------------------------------------
interface run_stepper_if #(
    parameter int DATA_W = 16,
    parameter int CNT_W  = 8
);
    logic              Start;
    logic              Stop;
    logic [7:0]        Step_N;
    logic              Done;
    logic [DATA_W-1:0] pc;
    logic              Trace_rd;
    logic              Run;
    logic              Busy;
    logic              Err;
    logic              Overflow;
    logic [7:0]        Retired;
    logic              Trace_valid;
    logic [DATA_W-1:0] Trace_pc;
    logic [CNT_W-1:0]  Trace_cyc;

    // Debug host / processor side.
    modport master (
        output Start, Stop, Step_N, Done, pc, Trace_rd,
        input  Run, Busy, Err, Overflow, Retired, Trace_valid, Trace_pc, Trace_cyc
    );

    // Stepper side.
    modport slave (
        input  Start, Stop, Step_N, Done, pc, Trace_rd,
        output Run, Busy, Err, Overflow, Retired, Trace_valid, Trace_pc, Trace_cyc
    );
endinterface

// File: rtl/run_stepper.sv
// ----------------------------------------------------------------------------
// run_stepper
//   Single-step / N-step controller for a processor core. While in RUN it
//   enables the processor, counts cycles per instruction, and logs
//   {pc, cycles} of every retired instruction into a first-word-fall-through
//   trace FIFO. Stepping ends after Step_N instructions (if nonzero) or on
//   Stop.
//
//   Optional feature: define RUN_STEPPER_TIMEOUT_EN to enable the
//   per-instruction timeout (RUN -> ERR when the cycle counter reaches
//   TIMEOUT without Done). Without it, Err is tied low and RUN never times
//   out.
//
//   Ports:
//     Clock  in  single clock, all state changes on rising edge
//     Reset  in  synchronous active-high reset
//     bus    run_stepper_if.slave  control, processor handshake, trace read
//
//   Parameters:
//     DATA_W  width of sampled pc
//     DEPTH   trace FIFO entries (power of two, >= 2)
//     CNT_W   width of per-instruction cycle counter
//     TIMEOUT max cycles per instruction before error (<= 2^CNT_W-1)
// ----------------------------------------------------------------------------
module run_stepper #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic          Clock,
    input  logic          Reset,
    run_stepper_if.slave  bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;   // extra wrap bit distinguishes full from empty
    localparam int EW = DATA_W + CNT_W;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
            TIMEOUT < 1 || TIMEOUT > (1 << CNT_W) - 1) begin : g_bad_params
            $error("run_stepper: illegal DEPTH/TIMEOUT/CNT_W combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ERR  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [7:0]        retired;
    logic [7:0]        step_n;
    logic              overflow;
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [EW-1:0]     mem [DEPTH];

    logic in_run;
    logic push_req;
    logic push_ok;
    logic pop;
    logic empty;
    logic full;
    logic start_ok;
    logic step_last;
    logic cnt_sat;
    logic timeout_hit;

    assign in_run    = (state == RUN);
    assign push_req  = in_run && bus.Done;
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign pop       = bus.Trace_rd && !empty;
    // A pop in the same cycle frees the head slot, so a full FIFO still accepts.
    assign push_ok   = push_req && (!full || pop);
    assign cnt_sat   = (cnt == {CNT_W{1'b1}});
    assign step_last = push_req && (step_n != 8'd0) && ((retired + 8'd1) == step_n);

`ifdef RUN_STEPPER_TIMEOUT_EN
    logic err;

    assign start_ok    = ((state == IDLE) && bus.Start && !bus.Stop) ||
                         ((state == ERR)  && bus.Start);
    assign timeout_hit = in_run && !bus.Done && (cnt >= CNT_W'(TIMEOUT));
    assign bus.Err     = err;
`else
    assign start_ok    = (state == IDLE) && bus.Start && !bus.Stop;
    assign timeout_hit = 1'b0;
    assign bus.Err     = 1'b0;
`endif

    // Control FSM, cycle counter, retire counter and sticky flags.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            retired  <= '0;
            step_n   <= '0;
            overflow <= 1'b0;
`ifdef RUN_STEPPER_TIMEOUT_EN
            err      <= 1'b0;
`endif
        end else begin
            if (start_ok) begin
                state    <= RUN;
                cnt      <= CNT_W'(1);
                retired  <= '0;
                step_n   <= bus.Step_N;
                overflow <= 1'b0;
`ifdef RUN_STEPPER_TIMEOUT_EN
                err      <= 1'b0;
`endif
            end else if (in_run) begin
                if (bus.Done) begin
                    retired <= retired + 8'd1;
                    cnt     <= CNT_W'(1);
                end else if (!cnt_sat) begin
                    cnt <= cnt + CNT_W'(1);
                end

                // Stop wins over timeout and budget exhaustion; a Done in
                // the same cycle has already been counted and logged above.
                if (bus.Stop) begin
                    state <= IDLE;
                end else if (timeout_hit) begin
                    state <= ERR;
`ifdef RUN_STEPPER_TIMEOUT_EN
                    err   <= 1'b1;
`endif
                end else if (step_last) begin
                    state <= IDLE;
                end
            end

            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // Trace FIFO pointers.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; emptiness is defined by the
    // pointers alone, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge Clock) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {bus.pc, cnt};
        end
    end

    assign bus.Run                      = in_run;
    assign bus.Busy                     = in_run;
    assign bus.Overflow                 = overflow;
    assign bus.Retired                  = retired;
    assign bus.Trace_valid              = !empty;
    assign {bus.Trace_pc, bus.Trace_cyc} = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_run_stepper.sv
// ----------------------------------------------------------------------------
// tb_run_stepper
//   Directed testbench for run_stepper (DEPTH=4, TIMEOUT=16, CNT_W=8).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that same
//   point, before new inputs are applied. With RUN_STEPPER_TIMEOUT_EN defined
//   the timeout path is exercised, otherwise counter saturation is.
// ----------------------------------------------------------------------------
module tb_run_stepper;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    run_stepper_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    run_stepper #(
        .DATA_W (DATA_W),
        .DEPTH  (4),
        .CNT_W  (CNT_W),
        .TIMEOUT(16)
    ) dut (
        .Clock(clk),
        .Reset(rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        logic [15:0] exp_pc [4];

        n_cmp        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        bus.Start    = 1'b0;
        bus.Stop     = 1'b0;
        bus.Step_N   = 8'd0;
        bus.Done     = 1'b0;
        bus.pc       = '0;
        bus.Trace_rd = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        rst = 1'b0;
        check("rst_run",      32'(bus.Run),         0);
        check("rst_busy",     32'(bus.Busy),        0);
        check("rst_err",      32'(bus.Err),         0);
        check("rst_ovf",      32'(bus.Overflow),    0);
        check("rst_retired",  32'(bus.Retired),     0);
        check("rst_valid",    32'(bus.Trace_valid), 0);

        // ---------------- Step_N=3, Done every 4th cycle ----------------
        bus.Step_N = 8'd3;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        check("s3_run",   32'(bus.Run),  1);
        check("s3_busy",  32'(bus.Busy), 1);
        for (int i = 0; i < 3; i++) begin
            repeat (3) tick();
            bus.Done = 1'b1;
            bus.pc   = 16'(i);
            tick();
            bus.Done = 1'b0;
            if (i == 1) check("s3_run_mid", 32'(bus.Run), 1);
        end
        check("s3_run_end",  32'(bus.Run),         0);
        check("s3_retired",  32'(bus.Retired),     3);
        check("s3_valid",    32'(bus.Trace_valid), 1);
        for (int i = 0; i < 3; i++) begin
            check("s3_pc",  32'(bus.Trace_pc),  32'(i));
            check("s3_cyc", 32'(bus.Trace_cyc), 4);
            bus.Trace_rd = 1'b1;
            tick();
            bus.Trace_rd = 1'b0;
        end
        check("s3_empty", 32'(bus.Trace_valid), 0);

        // ---------------- Done ignored in IDLE ----------------
        bus.Done = 1'b1;
        bus.pc   = 16'h55;
        tick();
        bus.Done = 1'b0;
        check("idle_done_valid",   32'(bus.Trace_valid), 0);
        check("idle_done_retired", 32'(bus.Retired),     3);

        // ---------------- Start and Stop together in IDLE ----------------
        bus.Start = 1'b1;
        bus.Stop  = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Stop  = 1'b0;
        check("ss_run",     32'(bus.Run),     0);
        check("ss_retired", 32'(bus.Retired), 3);

        // ---------------- DEPTH=4, Step_N=6, no reads -> overflow ----------------
        bus.Step_N = 8'd6;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.Done = 1'b1;
            bus.pc   = 16'(i);
            tick();
            if (i == 3) check("ov_not_yet", 32'(bus.Overflow), 0);
            if (i == 4) check("ov_set",     32'(bus.Overflow), 1);
        end
        bus.Done = 1'b0;
        check("ov_run",     32'(bus.Run),      0);
        check("ov_retired", 32'(bus.Retired),  6);
        check("ov_flag",    32'(bus.Overflow), 1);
        for (int i = 0; i < 4; i++) begin
            check("ov_pc",  32'(bus.Trace_pc),  32'(i));
            check("ov_cyc", 32'(bus.Trace_cyc), 1);
            bus.Trace_rd = 1'b1;
            tick();
            bus.Trace_rd = 1'b0;
        end
        check("ov_empty", 32'(bus.Trace_valid), 0);

        // Read from an empty FIFO is ignored.
        bus.Trace_rd = 1'b1;
        tick();
        bus.Trace_rd = 1'b0;
        check("rd_empty_valid", 32'(bus.Trace_valid), 0);

        // ---------------- full FIFO, push + pop same cycle ----------------
        bus.Step_N = 8'd0;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        check("start_clr_ovf", 32'(bus.Overflow), 0);
        for (int i = 0; i < 4; i++) begin
            bus.Done = 1'b1;
            bus.pc   = 16'(10 + i);
            tick();
        end
        check("full_head", 32'(bus.Trace_pc), 10);
        bus.Done     = 1'b1;
        bus.pc       = 16'd20;
        bus.Trace_rd = 1'b1;
        tick();
        bus.Done     = 1'b0;
        bus.Trace_rd = 1'b0;
        check("pp_ovf",  32'(bus.Overflow), 0);
        check("pp_head", 32'(bus.Trace_pc), 11);
        exp_pc[0] = 16'd11;
        exp_pc[1] = 16'd12;
        exp_pc[2] = 16'd13;
        exp_pc[3] = 16'd20;
        for (int i = 0; i < 4; i++) begin
            check("pp_pc", 32'(bus.Trace_pc), 32'(exp_pc[i]));
            bus.Trace_rd = 1'b1;
            tick();
            bus.Trace_rd = 1'b0;
        end
        check("pp_empty", 32'(bus.Trace_valid), 0);

        // ---------------- Stop with Done in the same cycle ----------------
        // Counter was reloaded to 1 after pc=20 and ran 4 more cycles.
        bus.Stop = 1'b1;
        bus.Done = 1'b1;
        bus.pc   = 16'd30;
        tick();
        bus.Stop = 1'b0;
        bus.Done = 1'b0;
        check("stop_run",     32'(bus.Run),         0);
        check("stop_valid",   32'(bus.Trace_valid), 1);
        check("stop_pc",      32'(bus.Trace_pc),    30);
        check("stop_cyc",     32'(bus.Trace_cyc),   5);
        check("stop_retired", 32'(bus.Retired),     6);

        // ---------------- Reset mid-run after 2 retired ----------------
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        bus.Done  = 1'b1;
        bus.pc    = 16'd40;
        tick();
        bus.pc    = 16'd41;
        tick();
        bus.Done  = 1'b0;
        check("mr_retired", 32'(bus.Retired), 2);
        check("mr_run",     32'(bus.Run),     1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_rst_run",     32'(bus.Run),         0);
        check("mr_rst_retired", 32'(bus.Retired),     0);
        check("mr_rst_valid",   32'(bus.Trace_valid), 0);

        // Reset wins over Start.
        rst       = 1'b1;
        bus.Start = 1'b1;
        tick();
        rst       = 1'b0;
        bus.Start = 1'b0;
        check("rst_vs_start", 32'(bus.Run), 0);

`ifdef RUN_STEPPER_TIMEOUT_EN
        // ---------------- timeout: TIMEOUT=16, no Done ----------------
        bus.Step_N = 8'd0;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        repeat (15) tick();
        check("to_run_15", 32'(bus.Run), 1);
        check("to_err_15", 32'(bus.Err), 0);
        tick();
        check("to_run_16", 32'(bus.Run), 0);
        check("to_err_16", 32'(bus.Err), 1);
        bus.Start = 1'b1;
        tick();
        bus.Start = 1'b0;
        check("to_restart_err", 32'(bus.Err), 0);
        check("to_restart_run", 32'(bus.Run), 1);
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
`else
        // ---------------- no timeout: counter saturates ----------------
        bus.Step_N = 8'd0;
        bus.Start  = 1'b1;
        tick();
        bus.Start  = 1'b0;
        repeat (300) tick();
        check("sat_err", 32'(bus.Err), 0);
        check("sat_run", 32'(bus.Run), 1);
        bus.Done = 1'b1;
        bus.pc   = 16'd7;
        tick();
        bus.Done = 1'b0;
        check("sat_pc",  32'(bus.Trace_pc),  7);
        check("sat_cyc", 32'(bus.Trace_cyc), 255);
        bus.Stop = 1'b1;
        tick();
        bus.Stop = 1'b0;
`endif
        check("end_run", 32'(bus.Run), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/run_stepper.md
RUN_STEPPER -- requirements
Module: run_stepper

Interface
REQ-001 SHALL provide parameter DATA_W, default 16: width of the sampled processor pc.
REQ-002 SHALL provide parameter DEPTH, default 8: trace FIFO entries, power of two, at least 2.
REQ-003 SHALL provide parameter CNT_W, default 8: width of the per-instruction cycle counter.
REQ-004 SHALL provide parameter TIMEOUT, default 64: maximum cycles per instruction before error, at most 2^CNT_W-1.
REQ-005 SHALL have port Clock  in  1  single clock; all state changes on rising edge.
REQ-006 SHALL have port Reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have port Start  in  1  one-cycle request to begin stepping.
REQ-008 SHALL have port Stop  in  1  one-cycle request to end stepping.
REQ-009 SHALL have port Step_N  in  8  instruction budget, latched at Start; 0 = run until Stop.
REQ-010 SHALL have port Done  in  1  processor instruction-complete strobe.
REQ-011 SHALL have port pc  in  DATA_W  processor pc, sampled in the Done cycle.
REQ-012 SHALL have port Trace_rd  in  1  pop the FIFO head.
REQ-013 SHALL have port Run  out  1  processor run enable.
REQ-014 SHALL have port Busy  out  1  high in RUN state.
REQ-015 SHALL have port Err  out  1  timeout flag.
REQ-016 SHALL have port Overflow  out  1  sticky trace-drop flag.
REQ-017 SHALL have port Retired  out  8  instructions retired since last Start.
REQ-018 SHALL have port Trace_valid  out  1  FIFO non-empty.
REQ-019 SHALL have ports Trace_pc  out  DATA_W  and Trace_cyc  out  CNT_W  FIFO head, first-word fall-through.

Function
REQ-020 SHALL implement states IDLE, RUN, ERR; Run = Busy = (state==RUN), registered.
REQ-021 SHALL go IDLE->RUN on Start with Stop low; Start and Stop together in IDLE stay IDLE; Start in RUN ignored.
REQ-022 SHALL, on entering RUN, clear Retired, latch Step_N, set cycle counter to 1.
REQ-023 SHALL, in RUN, increment the cycle counter each cycle without Done, saturating at 2^CNT_W-1.
REQ-024 SHALL, on Done in RUN, push {pc, counter value including the Done cycle}, increment Retired, reload counter to 1.
REQ-025 SHALL go RUN->IDLE in the cycle after the Done making Retired equal a nonzero latched Step_N.
REQ-026 SHALL go RUN->IDLE on Stop; a Done in the same cycle is still logged.
REQ-027 SHALL ignore Done outside RUN.
REQ-028 SHALL drop a push when FIFO is full and set Overflow; existing entries unchanged.
REQ-029 SHALL, on simultaneous push and pop with FIFO full, perform both with no Overflow.
REQ-030 SHALL ignore Trace_rd when FIFO empty; pointers wrap modulo DEPTH.
REQ-031 SHALL clear Overflow and Err only on Reset or accepted Start; FIFO contents persist across Start.

Reset
REQ-032 SHALL, at a clock edge with Reset high, force IDLE, Run=Busy=Err=Overflow=0, Retired=0, FIFO empty, counter 0.
REQ-033 SHALL give Reset priority over Start, Stop, Done and Trace_rd, including mid-run.

Configuration
REQ-034 SHALL, with macro RUN_STEPPER_TIMEOUT_EN defined, go RUN->ERR and set Err when the counter reaches TIMEOUT without Done; ERR exits to RUN only on Start.
REQ-035 SHALL, without RUN_STEPPER_TIMEOUT_EN, omit ERR logic; Err tied 0; RUN runs indefinitely.

Verification
REQ-036 Step_N=3, Done every 4th cycle, pc=0,1,2 -> three entries (0,4),(1,4),(2,4); Retired=3; Run low cycle after third Done.
REQ-037 Macro defined, TIMEOUT=16, Step_N=0, no Done -> Err=1, Run=0 after 16 RUN cycles; Start clears Err.
REQ-038 DEPTH=4, Step_N=6, no Trace_rd -> entries pc 0..3 retained, Overflow=1, Retired=6.
REQ-039 FIFO full, Done and Trace_rd same cycle -> head advances, new entry at tail, Overflow stays 0.
REQ-040 Reset high mid-run after 2 retired -> next cycle Run=0, Retired=0, Trace_valid=0.
REQ-041 Macro undefined, Step_N=0, no Done for 300 cycles -> Err=0, Trace_cyc of next entry saturates at 255.
